// File: rtl/inst_loader.sv
// inst_loader: streams bytes into big-endian instruction words and
// writes them to instruction memory while holding the CPU in stall.
module inst_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done
);

    localparam int CNT_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      byte_cnt;
    logic [23:0]     shift_buf;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] len_sat;
    logic [CNT_W-1:0] idx_nxt;
    logic            accept;

    // Saturate the requested length to memory capacity
    assign len_sat = (int'(len) > MAX_WORDS) ? CNT_W'(MAX_WORDS)
                                             : CNT_W'(len);
    assign idx_nxt = word_idx + CNT_W'(1);
    assign accept  = in_valid && (state == LOAD);

    assign in_ready = (state == LOAD);
    assign mem_we   = (state == WRITE);
    assign done     = (state == DONE);
    assign cpu_hold = (state != DONE);

    // Load sequencer: byte assembly, word write and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= 2'd0;
            shift_buf <= 24'd0;
            word_idx  <= '0;
            len_eff   <= '0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_eff  <= len_sat;
                        word_idx <= '0;
                        byte_cnt <= 2'd0;
                        state    <= (len_sat == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (byte_cnt == 2'd3) begin
                            mem_wdata <= {shift_buf, in_data};
                            mem_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
                            byte_cnt  <= 2'd0;
                            state     <= WRITE;
                        end else begin
                            shift_buf <= {shift_buf[15:0], in_data};
                            byte_cnt  <= byte_cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    word_idx <= idx_nxt;
                    state    <= (idx_nxt == len_eff) ? DONE : LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: randomized byte streams checked against a
// queue-based model of the expected memory writes.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  len = 7'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t        got[$];
    logic [7:0] stim[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    inst_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) got.push_back('{a: mem_addr, d: mem_wdata, c: cyc});
        if (!rst) chk("rdy_we_excl", 64'(in_ready & mem_we), 64'd0);
    end

    task automatic fill(input int nb, input bit seq);
        stim.delete();
        for (int i = 0; i < nb; i++)
            stim.push_back(seq ? 8'(i) : 8'($urandom_range(255)));
    endtask

    // Feed bytes stim[0..nb-1]; returns count accepted
    task automatic feed(input int nb, input int gap, input bit poke,
                        output int idx);
        int t;
        idx = 0;
        t = 0;
        while (idx < nb && t < nb * 40 + 100) begin
            in_valid = ($urandom_range(99) >= gap);
            in_data  = stim[idx];
            start    = poke && (t == 6);
            if (poke && t == 6) len = 7'd9;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_load(input int ln, input int gap, input bit poke);
        int n_eff, nb, idx, t, done_c;
        logic [31:0] w;
        n_eff = (ln > 64) ? 64 : ln;
        nb = 4 * n_eff;
        got.delete();
        @(negedge clk);
        start = 1'b1;
        len   = 7'(ln);
        @(negedge clk);
        start = 1'b0;
        if (n_eff == 0) begin
            chk("len0_done", 64'(done), 64'd1);
            chk("len0_hold", 64'(cpu_hold), 64'd0);
            repeat (3) @(negedge clk);
            chk("len0_nowr", 64'(got.size()), 64'd0);
            return;
        end
        chk("start_state", 64'({done, cpu_hold, in_ready}), 64'd3);
        feed(nb, gap, poke, idx);
        chk("feed_cnt", 64'(idx), 64'(nb));
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        done_c = cyc;
        chk("done", 64'(done), 64'd1);
        chk("hold", 64'(cpu_hold), 64'd0);
        chk("nwr", 64'(got.size()), 64'(n_eff));
        for (int i = 0; i < n_eff && i < got.size(); i++) begin
            w = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
            chk("wr_addr", 64'(got[i].a), 64'((i * 4) % 256));
            chk("wr_data", 64'(got[i].d), 64'(w));
        end
        if (got.size() > 0)
            chk("done_lat", 64'(done_c), 64'(got[got.size()-1].c + 1));
    endtask

    initial begin
        int idx;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_idle",
                64'({cpu_hold, done, in_ready, mem_we, mem_addr, mem_wdata}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0}));
        end

        stim = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_load(1, 0, 1'b0);

        fill(12, 1'b1);
        run_load(3, 40, 1'b0);

        run_load(0, 0, 1'b0);

        fill(256, 1'b0);
        run_load(100, 10, 1'b0);
        chk("last_addr", 64'(got[got.size()-1].a), 64'hFC);

        fill(8, 1'b0);
        got.delete();
        @(negedge clk);
        start = 1'b1;
        len   = 7'd2;
        @(negedge clk);
        start = 1'b0;
        feed(6, 0, 1'b0, idx);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rst_idle", 64'({in_ready, mem_we, done, cpu_hold}), 64'd1);
        end
        chk("rst_nwr", 64'(got.size()), 64'd1);

        fill(4, 1'b0);
        run_load(1, 30, 1'b0);

        fill(12, 1'b0);
        run_load(3, 20, 1'b1);

        fill(8, 1'b0);
        run_load(2, 25, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int ln;
            ln = $urandom_range(1, 12);
            fill(4 * ln, 1'b0);
            run_load(ln, $urandom_range(0, 60), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that writes the instruction memory the pipelined datapath fetches from. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one write per word to consecutive word-aligned byte addresses starting at 0. It holds the CPU in stall (`cpu_hold`) until a load completes, then releases it.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory byte-address width (matches the datapath's `pc_out[7:0]`).
- `MAX_WORDS`, 64: capacity in words (2^ADDR_W / 4).

Ports:
- `clk`  in  1  clock; every register updates on its rising edge.
- `rst`  in  1  reset: one clock, synchronous, active-high.
- `start`  in  1  begin a load; sampled in IDLE and DONE only.
- `len`  in  7  word count, latched with `start`. Values above MAX_WORDS saturate to MAX_WORDS.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  byte address of the word being written.
- `mem_wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  high while the CPU must not fetch.
- `done`  out  1  load complete; sticky until the next `start` or `rst`.

## Operation
- States: IDLE, LOAD, WRITE, DONE. All outputs are registered or decoded from state.
- Reset: state enters IDLE. `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `cpu_hold`=1. Byte counter, word index and shift buffer clear.
- IDLE: on `start`, latch `len_eff = min(len, MAX_WORDS)` and clear the word index.
  - If `len_eff`=0, go to DONE with no writes.
  - Otherwise go to LOAD.
- LOAD: `in_ready`=1. A byte is accepted on each edge where `in_valid && in_ready`.
  - Accepted bytes shift in MSB-first: the 1st byte lands in [31:24], the 4th in [7:0].
  - On acceptance of the 4th byte, register `mem_wdata`=assembled word and `mem_addr`=word_idx*4, then go to WRITE.
  - Cycles with `in_valid`=0 cause no state change.
- WRITE: `in_ready`=0 and `mem_we`=1 for exactly one cycle. The word index then increments.
  - If the new index equals `len_eff`, go to DONE; otherwise go to LOAD.
- DONE: `done`=1 and `cpu_hold`=0.
  - `start` begins a new load: the next state is LOAD (or DONE again if `len_eff`=0), `done` drops to 0 and `cpu_hold` rises to 1.
- `cpu_hold` = (state != DONE).
- `start` in LOAD or WRITE is ignored. `len` is not re-sampled mid-load.
- `mem_addr` and `mem_wdata` hold their last values outside WRITE.
- Address arithmetic is ADDR_W bits. word_idx ranges 0..MAX_WORDS-1, so the last address is 0xFC and never wraps.
- `rst` mid-load returns the block to IDLE:
  - a partial word is discarded and never written;
  - words already written remain in memory;
  - `cpu_hold`=1.

## Timing
- `start` sampled at edge N: state is LOAD from N (`in_ready`=1 in cycle N..N+1).
- 4th byte accepted at edge K: `mem_we`=1 in cycle K..K+1, and memory captures the word at edge K+1.
- Best-case throughput: 5 cycles per word (4 accept cycles + 1 write cycle).
- Final write at edge W: `done`=1 and `cpu_hold`=0 from edge W onward.
- `len_eff`=0: `done`=1 one cycle after `start`.
- `in_ready` never asserts in the same cycle as `mem_we`.

## Test plan
- Reset, then idle for 5 cycles: `cpu_hold`=1, `done`=0, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0 throughout.
- `start`, `len`=1, bytes 0x12,0x34,0x56,0x78 back-to-back: exactly one `mem_we` pulse with addr 0x00 and data 0x12345678; `done`=1 and `cpu_hold`=0 the cycle after the write.
- `len`=3 with random `in_valid` gaps and bytes 0x00..0x0B: writes to 0x00, 0x04, 0x08 with data 0x00010203, 0x04050607, 0x08090A0B; no write occurs while bytes are missing.
- `len`=0: no `mem_we` pulse and `done`=1 one cycle after `start`. `len`=100: exactly 64 writes, last address 0xFC.
- Pulse `rst` after 2 bytes of word 1 (word 0 already written): no further `mem_we`, state is IDLE, `cpu_hold`=1. A subsequent `len`=1 load rewrites address 0x00.
- `start` asserted mid-LOAD is ignored (write count unchanged). `start` in DONE with `len`=2 drops `done` and raises `cpu_hold`, then performs 2 writes at 0x00 and 0x04.
